game_physics: RTL and testbench

GAME_PHYSICS -- requirements
Module: game_physics

---
 rtl/game_physics.sv | 119 +++++++++++
 tb/tb_game_physics.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_physics.sv
// Endless-runner physics core: one jumping player, one scrolling obstacle,
// per-tick ballistic update, obstacle wrap with scoring, and collision detection.
module game_physics #(
  parameter int SCREEN_W = 160,
  parameter int PLAYER_X = 20,
  parameter int PLAYER_W = 8,
  parameter int OBS_W    = 8,
  parameter int OBS_H    = 12,
  parameter int SPEED    = 2,
  parameter int JUMP_V   = 10,
  parameter int GRAVITY  = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       start,
  input  logic       jump,
  output logic [6:0] player_h,
  output logic [7:0] obs_x,
  output logic [7:0] score,
  output logic       running,
  output logic       endgame
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [7:0] SPAWN_X = 8'(SCREEN_W - 1);

  state_t            state;
  logic signed [5:0] vel;
  logic              jump_pend;

  logic signed [5:0] vel_eff;
  logic signed [7:0] new_h;
  logic        [6:0] h_nxt;
  logic signed [5:0] vel_nxt;
  logic        [7:0] obs_nxt;
  logic        [7:0] score_nxt;
  logic              hit;

  // Next-frame values, computed every cycle and committed only on a RUN tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    h_nxt     = 7'd0;
    vel_nxt   = 6'sd0;
    obs_nxt   = obs_x;
    score_nxt = score;

    // A pending jump launches only from rest on the ground.
    vel_eff = (jump_pend && player_h == 7'd0 && vel == 6'sd0) ? 6'(JUMP_V) : vel;
    new_h   = $signed({1'b0, player_h}) + $signed({{2{vel_eff[5]}}, vel_eff});
    if (new_h > 8'sd0) begin
      h_nxt   = new_h[6:0];
      vel_nxt = vel_eff - 6'(GRAVITY);
    end

    if (obs_x < 8'(SPEED)) begin
      obs_nxt   = SPAWN_X;
      score_nxt = (score == 8'hFF) ? score : score + 8'd1;
    end else begin
      obs_nxt = obs_x - 8'(SPEED);
    end

    // Horizontal overlap in 9 bits so obs_x + OBS_W cannot wrap.
    hit = ({1'b0, obs_nxt} < 9'(PLAYER_X + PLAYER_W)) &&
          (({1'b0, obs_nxt} + 9'(OBS_W)) > 9'(PLAYER_X)) &&
          (h_nxt < 7'(OBS_H));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      player_h  <= 7'd0;
      vel       <= 6'sd0;
      obs_x     <= SPAWN_X;
      score     <= 8'd0;
      jump_pend <= 1'b0;
      running   <= 1'b0;
      endgame   <= 1'b0;
    end else if (start) begin
      // Start from any state (re)loads a fresh round and overrides a same-cycle tick.
      state     <= RUN;
      player_h  <= 7'd0;
      vel       <= 6'sd0;
      obs_x     <= SPAWN_X;
      score     <= 8'd0;
      jump_pend <= 1'b0;
      running   <= 1'b1;
      endgame   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            player_h  <= h_nxt;
            vel       <= vel_nxt;
            obs_x     <= obs_nxt;
            score     <= score_nxt;
            jump_pend <= 1'b0;
            if (hit) begin
              state   <= OVER;
              running <= 1'b0;
              endgame <= 1'b1;
            end
          end else if (jump) begin
            jump_pend <= 1'b1;
          end
        end
        IDLE, OVER: ;
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          endgame <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_physics.sv
// Self-checking bench for game_physics: directed scenarios with literal
// expectations plus randomized play compared every cycle to a behavioural model.
module tb_game_physics;

  localparam int SCREEN_W = 160;
  localparam int PLAYER_X = 20;
  localparam int PLAYER_W = 8;
  localparam int OBS_W    = 8;
  localparam int OBS_H    = 12;
  localparam int SPEED    = 2;
  localparam int JUMP_V   = 10;
  localparam int GRAVITY  = 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       jump = 1'b0;
  logic [6:0] player_h;
  logic [7:0] obs_x;
  logic [7:0] score;
  logic       running;
  logic       endgame;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Behavioural model of the game.
  bit m_run   = 1'b0;
  bit m_over  = 1'b0;
  int m_h     = 0;
  int m_v     = 0;
  int m_x     = SCREEN_W - 1;
  int m_sc    = 0;
  bit m_pend  = 1'b0;

  int arc [21] = '{10, 19, 27, 34, 40, 45, 49, 52, 54, 55, 55,
                   54, 52, 49, 45, 40, 34, 27, 19, 10, 0};

  game_physics #(
    .SCREEN_W(SCREEN_W), .PLAYER_X(PLAYER_X), .PLAYER_W(PLAYER_W),
    .OBS_W(OBS_W), .OBS_H(OBS_H), .SPEED(SPEED), .JUMP_V(JUMP_V), .GRAVITY(GRAVITY)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start), .jump(jump),
    .player_h(player_h), .obs_x(obs_x), .score(score),
    .running(running), .endgame(endgame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_over = 1'b0; m_h = 0; m_v = 0;
    m_x = SCREEN_W - 1; m_sc = 0; m_pend = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit j);
    int ve;
    int nh;
    if (s) begin
      model_reset();
      m_run = 1'b1;
    end else if (m_run) begin
      if (t) begin
        ve = (m_pend && m_h == 0 && m_v == 0) ? JUMP_V : m_v;
        nh = m_h + ve;
        if (nh <= 0) begin
          m_h = 0; m_v = 0;
        end else begin
          m_h = nh; m_v = ve - GRAVITY;
        end
        m_pend = 1'b0;
        if (m_x < SPEED) begin
          m_x = SCREEN_W - 1;
          if (m_sc < 255) m_sc++;
        end else begin
          m_x = m_x - SPEED;
        end
        if (m_x < PLAYER_X + PLAYER_W && m_x + OBS_W > PLAYER_X && m_h < OBS_H) begin
          m_run = 1'b0; m_over = 1'b1;
        end
      end else if (j) begin
        m_pend = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step(tick, start, jump);
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("player_h", int'(player_h), m_h);
      check("obs_x",    int'(obs_x),    m_x);
      check("score",    int'(score),    m_sc);
      check("running",  int'(running),  int'(m_run));
      check("endgame",  int'(endgame),  int'(m_over));
    end
  end

  // Inputs are applied 1ns after a rising edge and held for one full cycle.
  task automatic cyc(input bit t, input bit s, input bit j);
    tick = t; start = s; jump = j;
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; jump = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_h"},       int'(player_h), 0);
    check({tag, "_x"},       int'(obs_x),    159);
    check({tag, "_score"},   int'(score),    0);
    check({tag, "_running"}, int'(running),  0);
    check({tag, "_endgame"}, int'(endgame),  0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #20;
    check_reset_values("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // Plain run into the obstacle.
    cyc(1'b0, 1'b1, 1'b0);
    check("start_running", int'(running), 1);
    ticks(1);
    check("tick1_x", int'(obs_x), 157);
    ticks(1);
    check("tick2_x", int'(obs_x), 155);
    ticks(62);
    ticks(1);
    check("tick65_x", int'(obs_x), 29);
    check("tick65_running", int'(running), 1);
    ticks(1);
    check("tick66_x", int'(obs_x), 27);
    check("tick66_endgame", int'(endgame), 1);
    check("tick66_running", int'(running), 0);
    check("tick66_score", int'(score), 0);

    // Frozen in OVER, then start and tick together.
    ticks(5);
    cyc(1'b0, 1'b0, 1'b1);
    check("over_frozen_x", int'(obs_x), 27);
    cyc(1'b1, 1'b1, 1'b0);
    check("restart_x", int'(obs_x), 159);
    check("restart_running", int'(running), 1);
    check("restart_endgame", int'(endgame), 0);

    // Full jump arc.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) begin
      ticks(1);
      check($sformatf("arc_%0d", i), int'(player_h), arc[i]);
    end
    cyc(1'b0, 1'b0, 1'b1);
    ticks(1);
    check("relaunch_h", int'(player_h), 10);

    // Airborne jump is dropped; arc unchanged.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) begin
      ticks(1);
      if (i == 4) cyc(1'b0, 1'b0, 1'b1);
      check($sformatf("arc2_%0d", i), int'(player_h), arc[i]);
    end
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b1);
    check("notick_h", int'(player_h), 0);

    // Jump clears the first obstacle, which then wraps for a point.
    cyc(1'b0, 1'b1, 1'b0);
    ticks(64);
    cyc(1'b0, 1'b0, 1'b1);
    ticks(1);
    for (int t = 66; t <= 80; t++) begin
      ticks(1);
      if (t <= 73) check($sformatf("clear_h_t%0d", t), int'(player_h >= 7'd12), 1);
    end
    check("wrap_x", int'(obs_x), 159);
    check("wrap_score", int'(score), 1);
    check("wrap_endgame", int'(endgame), 0);

    // Asynchronous reset mid-arc.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    ticks(5);
    check("midarc_h", int'(player_h), 40);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    ticks(3);
    check("after_reset_idle_x", int'(obs_x), 159);
    check("after_reset_idle_running", int'(running), 0);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      bit t;
      bit s;
      bit j;
      t = ($urandom_range(0, 1) == 1);
      s = m_run ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 15) == 0);
      j = ($urandom_range(0, 11) == 0);
      cyc(t, s, j);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
